// File: rtl/fifo_cbb_par_wr.sv
// fifo_cbb_par_wr
//   Write-side front end for a parity-protected fifo_cbb (clk_wr domain).
//   A two-entry skid buffer takes user words over valid/ready and drains
//   them into the FIFO whenever fifo_afull is low. Each word is written as
//   {even_parity, data}. Writes into a full FIFO are flagged but still issued.
//
//   Optional feature macro: FIFO_CBB_PAR_INJ_EN
//     Adds err_inj / err_inj_done. An err_inj pulse arms a one-shot that
//     inverts the parity bit of the next word written.
//
// Ports:
//   clk_wr        in   write clock
//   wr_reset      in   asynchronous active-high reset
//   usr_valid     in   user word valid
//   usr_data      in   user word [FIFO_WIDTH-1:0]
//   usr_ready     out  buffer can accept (decoded from occupancy only)
//   fifo_afull    in   FIFO programmable almost-full
//   fifo_full     in   FIFO full (overflow detection only)
//   fifo_wen      out  FIFO write enable (registered)
//   fifo_wdata    out  {parity, data} [FIFO_WIDTH:0] (registered)
//   wr_cnt        out  words written, wraps
//   ovf_err       out  fifo_wen & fifo_full
//   ovf_err_flag  out  sticky ovf_err
//   err_inj       in   arm parity inversion       (FIFO_CBB_PAR_INJ_EN)
//   err_inj_done  out  inverted word being written (FIFO_CBB_PAR_INJ_EN)

module fifo_cbb_par_wr #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_wr,
  input  logic                  wr_reset,
  input  logic                  usr_valid,
  input  logic [FIFO_WIDTH-1:0] usr_data,
  output logic                  usr_ready,
  input  logic                  fifo_afull,
  input  logic                  fifo_full,
  output logic                  fifo_wen,
  output logic [FIFO_WIDTH:0]   fifo_wdata,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic                  ovf_err,
`ifdef FIFO_CBB_PAR_INJ_EN
  output logic                  ovf_err_flag,
  input  logic                  err_inj,
  output logic                  err_inj_done
`else
  output logic                  ovf_err_flag
`endif
);

  logic [1:0]            r_cnt;
  logic [FIFO_WIDTH-1:0] r_buf [2];
  logic                  r_wen;
  logic [FIFO_WIDTH:0]   r_wdata;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic                  r_ovf_flag;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_tail;
  logic                  w_par;
  logic [1:0]            w_cnt_nxt;

  assign usr_ready = (r_cnt != 2'd2);
  assign w_accept  = usr_valid & usr_ready;
  assign w_pop     = (r_cnt != 2'd0) & ~fifo_afull;

  // Entry 0 is always the head; a pop shifts entry 1 down, so the tail slot
  // for an incoming word is the occupancy left after this cycle's pop.
  assign w_tail = (r_cnt == 2'd1) & ~w_pop;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_accept, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

`ifdef FIFO_CBB_PAR_INJ_EN
  logic r_armed;
  logic r_inj_done;
  logic w_inj;

  // Only an already-armed one-shot affects the current pop, so an err_inj
  // coincident with a pop applies to the following one.
  assign w_inj        = r_armed & w_pop;
  assign err_inj_done = r_inj_done;

  always_ff @(posedge clk_wr or posedge wr_reset) begin
    if (wr_reset) begin
      r_armed    <= 1'b0;
      r_inj_done <= 1'b0;
    end else begin
      r_inj_done <= w_inj;
      if (w_inj)
        r_armed <= 1'b0;
      else if (err_inj)
        r_armed <= 1'b1;
    end
  end

  assign w_par = (^r_buf[0]) ^ w_inj;
`else
  assign w_par = ^r_buf[0];
`endif

  always_ff @(posedge clk_wr or posedge wr_reset) begin
    if (wr_reset) begin
      r_cnt    <= '0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_pop)
        r_buf[0] <= r_buf[1];
      if (w_accept)
        r_buf[w_tail] <= usr_data;
    end
  end

  always_ff @(posedge clk_wr or posedge wr_reset) begin
    if (wr_reset) begin
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wr_cnt   <= '0;
      r_ovf_flag <= 1'b0;
    end else begin
      r_wen <= w_pop;
      if (w_pop) begin
        r_wdata  <= {w_par, r_buf[0]};
        r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
      end
      if (ovf_err)
        r_ovf_flag <= 1'b1;
    end
  end

  assign fifo_wen     = r_wen;
  assign fifo_wdata   = r_wdata;
  assign wr_cnt       = r_wr_cnt;
  assign ovf_err      = r_wen & fifo_full;
  assign ovf_err_flag = r_ovf_flag;

endmodule

// File: tb/tb_fifo_cbb_par_wr.sv
module tb_fifo_cbb_par_wr;

  logic        clk_wr = 1'b0;
  logic        wr_reset = 1'b1;
  logic        usr_valid = 1'b0;
  logic [7:0]  usr_data = '0;
  logic        usr_ready;
  logic        fifo_afull = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wen;
  logic [8:0]  fifo_wdata;
  logic [31:0] wr_cnt;
  logic        ovf_err;
  logic        ovf_err_flag;
`ifdef FIFO_CBB_PAR_INJ_EN
  logic        err_inj = 1'b0;
  logic        err_inj_done;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_wr_cnt = '0;

  always #5 clk_wr = ~clk_wr;

  fifo_cbb_par_wr #(.FIFO_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk_wr       (clk_wr),
    .wr_reset     (wr_reset),
    .usr_valid    (usr_valid),
    .usr_data     (usr_data),
    .usr_ready    (usr_ready),
    .fifo_afull   (fifo_afull),
    .fifo_full    (fifo_full),
    .fifo_wen     (fifo_wen),
    .fifo_wdata   (fifo_wdata),
    .wr_cnt       (wr_cnt),
    .ovf_err      (ovf_err),
`ifdef FIFO_CBB_PAR_INJ_EN
    .ovf_err_flag (ovf_err_flag),
    .err_inj      (err_inj),
    .err_inj_done (err_inj_done)
`else
    .ovf_err_flag (ovf_err_flag)
`endif
  );

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    wr_reset = 1'b1;
    step();
    step();
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b exp 0", fifo_wen); end
    n_checks++;
    if (fifo_wdata !== 9'h000) begin n_fail++; $display("FAIL reset_wdata got %h exp 000", fifo_wdata); end
    n_checks++;
    if (wr_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_wr_cnt got %0d exp 0", wr_cnt); end
    n_checks++;
    if (ovf_err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_flag got %b exp 0", ovf_err_flag); end
    wr_reset = 1'b0;
    step();
    n_checks++;
    if (usr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", usr_ready); end
    exp_wr_cnt = '0;
  endtask

  task automatic test_single();
    usr_valid = 1'b1;
    usr_data  = 8'hA5;
    step();                 // accept
    usr_valid = 1'b0;
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL single_wen_n1 got %b exp 0", fifo_wen); end
    step();                 // pop registered
    n_checks++;
    if (fifo_wen !== 1'b1) begin n_fail++; $display("FAIL single_wen_n2 got %b exp 1", fifo_wen); end
    n_checks++;
    if (fifo_wdata !== 9'h0A5) begin n_fail++; $display("FAIL single_wdata got %h exp 0a5", fifo_wdata); end
    exp_wr_cnt = exp_wr_cnt + 1;
    n_checks++;
    if (wr_cnt !== 32'd1) begin n_fail++; $display("FAIL single_wr_cnt got %0d exp 1", wr_cnt); end
    step();
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL single_wen_n3 got %b exp 0", fifo_wen); end
    n_checks++;
    if (fifo_wdata !== 9'h0A5) begin n_fail++; $display("FAIL single_hold got %h exp 0a5", fifo_wdata); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int j = 0; j < 258; j++) begin
      usr_valid = (j < 256);
      usr_data  = 8'(j);
      if (j < 256) begin
        n_checks++;
        if (usr_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready j=%0d got %b exp 1", j, usr_ready); end
      end
      step();
      if (j >= 1 && j <= 256) begin
        d = 8'(j - 1);
        n_checks++;
        if (fifo_wen !== 1'b1) begin n_fail++; $display("FAIL stream_wen j=%0d got %b exp 1", j, fifo_wen); end
        n_checks++;
        if (fifo_wdata !== {^d, d}) begin n_fail++; $display("FAIL stream_wdata j=%0d got %h exp %h", j, fifo_wdata, {^d, d}); end
        n_checks++;
        if ((^fifo_wdata) !== 1'b0) begin n_fail++; $display("FAIL stream_even_par j=%0d got %b exp 0", j, ^fifo_wdata); end
      end
    end
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL stream_end_wen got %b exp 0", fifo_wen); end
    exp_wr_cnt = exp_wr_cnt + 256;
    n_checks++;
    if (wr_cnt !== exp_wr_cnt) begin n_fail++; $display("FAIL stream_wr_cnt got %0d exp %0d", wr_cnt, exp_wr_cnt); end
  endtask

  task automatic test_afull();
    fifo_afull = 1'b1;
    usr_valid  = 1'b1;
    usr_data   = 8'h13;
    step();                 // 0x13 accepted, cnt=1
    usr_data = 8'h22;
    n_checks++;
    if (usr_ready !== 1'b1) begin n_fail++; $display("FAIL afull_ready1 got %b exp 1", usr_ready); end
    step();                 // 0x22 accepted, cnt=2
    usr_data = 8'h37;
    n_checks++;
    if (usr_ready !== 1'b0) begin n_fail++; $display("FAIL afull_ready_full got %b exp 0", usr_ready); end
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL afull_wen_a got %b exp 0", fifo_wen); end
    step();                 // 0x37 refused
    n_checks++;
    if (usr_ready !== 1'b0) begin n_fail++; $display("FAIL afull_ready_hold got %b exp 0", usr_ready); end
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL afull_wen_b got %b exp 0", fifo_wen); end
    fifo_afull = 1'b0;      // cycle M: pop 0x13
    step();
    n_checks++;
    if (fifo_wen !== 1'b1 || fifo_wdata !== 9'h113) begin n_fail++; $display("FAIL afull_w0 got wen=%b %h exp 1 113", fifo_wen, fifo_wdata); end
    n_checks++;
    if (usr_ready !== 1'b1) begin n_fail++; $display("FAIL afull_ready_back got %b exp 1", usr_ready); end
    step();                 // 0x37 accepted, 0x22 popped
    usr_valid = 1'b0;
    n_checks++;
    if (fifo_wen !== 1'b1 || fifo_wdata !== 9'h022) begin n_fail++; $display("FAIL afull_w1 got wen=%b %h exp 1 022", fifo_wen, fifo_wdata); end
    step();
    n_checks++;
    if (fifo_wen !== 1'b1 || fifo_wdata !== 9'h137) begin n_fail++; $display("FAIL afull_w2 got wen=%b %h exp 1 137", fifo_wen, fifo_wdata); end
    step();
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL afull_w3 got %b exp 0", fifo_wen); end
    exp_wr_cnt = exp_wr_cnt + 3;
    n_checks++;
    if (wr_cnt !== exp_wr_cnt) begin n_fail++; $display("FAIL afull_wr_cnt got %0d exp %0d", wr_cnt, exp_wr_cnt); end
  endtask

  task automatic test_ovf();
    fifo_full = 1'b1;
    usr_valid = 1'b1;
    usr_data  = 8'h01;
    step();
    usr_valid = 1'b0;
    n_checks++;
    if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_idle got %b exp 0", ovf_err); end
    step();
    n_checks++;
    if (fifo_wen !== 1'b1 || fifo_wdata !== 9'h101) begin n_fail++; $display("FAIL ovf_write got wen=%b %h exp 1 101", fifo_wen, fifo_wdata); end
    n_checks++;
    if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", ovf_err); end
    n_checks++;
    if (ovf_err_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_early got %b exp 0", ovf_err_flag); end
    step();
    n_checks++;
    if (ovf_err_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_set got %b exp 1", ovf_err_flag); end
    fifo_full = 1'b0;
    step();
    step();
    n_checks++;
    if (ovf_err_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_flag_sticky got %b exp 1", ovf_err_flag); end
    exp_wr_cnt = exp_wr_cnt + 1;
    n_checks++;
    if (wr_cnt !== exp_wr_cnt) begin n_fail++; $display("FAIL ovf_wr_cnt got %0d exp %0d", wr_cnt, exp_wr_cnt); end
  endtask

  task automatic test_reset_mid();
    fifo_afull = 1'b1;
    usr_valid  = 1'b1;
    usr_data   = 8'h5A;
    step();
    usr_data = 8'hC3;
    step();
    usr_valid = 1'b0;
    n_checks++;
    if (usr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_full got %b exp 0", usr_ready); end
    fifo_afull = 1'b0;
    step();                 // 0x5A written, 0xC3 still buffered
    n_checks++;
    if (fifo_wen !== 1'b1 || fifo_wdata !== 9'h05A) begin n_fail++; $display("FAIL rst_mid_w0 got wen=%b %h exp 1 05a", fifo_wen, fifo_wdata); end
    #1;
    wr_reset = 1'b1;
    #1;
    n_checks++;
    if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async_wen got %b exp 0", fifo_wen); end
    n_checks++;
    if (usr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b exp 1", usr_ready); end
    n_checks++;
    if (ovf_err_flag !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flag got %b exp 0", ovf_err_flag); end
    step();
    step();
    wr_reset = 1'b0;
    exp_wr_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (fifo_wen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_write k=%0d got %b exp 0", k, fifo_wen); end
    end
    n_checks++;
    if (wr_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_mid_wr_cnt got %0d exp 0", wr_cnt); end
  endtask

`ifdef FIFO_CBB_PAR_INJ_EN
  task automatic test_err_inj();
    err_inj = 1'b1;
    step();
    err_inj   = 1'b0;
    usr_valid = 1'b1;
    usr_data  = 8'h03;
    step();                 // first 0x03 accepted
    step();                 // second 0x03 accepted, first written
    usr_valid = 1'b0;
    n_checks++;
    if (fifo_wen !== 1'b1 || fifo_wdata !== 9'h103) begin n_fail++; $display("FAIL inj_word got wen=%b %h exp 1 103", fifo_wen, fifo_wdata); end
    n_checks++;
    if (err_inj_done !== 1'b1) begin n_fail++; $display("FAIL inj_done got %b exp 1", err_inj_done); end
    step();
    n_checks++;
    if (fifo_wen !== 1'b1 || fifo_wdata !== 9'h003) begin n_fail++; $display("FAIL inj_next got wen=%b %h exp 1 003", fifo_wen, fifo_wdata); end
    n_checks++;
    if (err_inj_done !== 1'b0) begin n_fail++; $display("FAIL inj_done_clr got %b exp 0", err_inj_done); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_afull();
    test_ovf();
    test_reset_mid();
`ifdef FIFO_CBB_PAR_INJ_EN
    test_err_inj();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
